// File: rtl/timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Purpose  : Per-channel grant-hold limiter placed between CHANNELS requesters
//            and an arbiter. Each channel masks its request once it has held a
//            grant for 'limit' cycles. It then sits out a HOLDOFF period and
//            raises a one-cycle timeout pulse.
// Options  : TIMER_STATS_EN adds per-channel saturating expiry counters
//            on the expire_count output bus.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module timer_multi #(
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 16,
   parameter int HOLDOFF     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [COUNT_WIDTH-1:0]   limit,
   input  logic [CHANNELS-1:0]      up_req,
   output logic [CHANNELS-1:0]      up_grant,
   input  logic [CHANNELS-1:0]      up_ack,
   output logic [CHANNELS-1:0]      down_req,
   input  logic [CHANNELS-1:0]      down_grant,
   output logic [CHANNELS-1:0]      down_ack,
`ifdef TIMER_STATS_EN
   output logic [CHANNELS*16-1:0]   expire_count,
`endif
   output logic [CHANNELS-1:0]      timeout_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   // Last holdoff count value; clamped so HOLDOFF=0 still elaborates cleanly.
   localparam int                     HOLD_LAST_I = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
   localparam logic [COUNT_WIDTH-1:0] HOLD_LAST   = COUNT_WIDTH'(HOLD_LAST_I);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

   // Grant and acknowledge pass straight through.
   assign up_grant = down_grant;
   assign down_ack = up_ack;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t                 state_q, state_d;
      logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                   pulse_q;
      logic                   expired;
      logic                   expire_evt;

      // Channel is over its budget; >= lets a lowered limit bite at once.
      always_comb begin
         expired = (state_q == ST_GRANTED) && (limit != '0) && (cnt_q >= limit);
      end

      // Request mask; during reset the request is passed through unmodified.
      always_comb begin
         if (rst) begin
            down_req[i] = up_req[i];
         end else begin
            down_req[i] = up_req[i] & ~expired & (state_q != ST_HOLDOFF);
         end
      end

      // Next-state and counter logic for one channel.
      always_comb begin
         state_d    = state_q;
         cnt_d      = cnt_q;
         expire_evt = 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (down_grant[i]) begin
                  state_d = ST_GRANTED;
                  cnt_d   = COUNT_WIDTH'(1);
               end
            end
            ST_GRANTED: begin
               if (expired) begin
                  // Expiry wins over a simultaneous grant drop.
                  expire_evt = 1'b1;
                  cnt_d      = '0;
                  state_d    = (HOLDOFF > 0) ? ST_HOLDOFF : ST_IDLE;
               end else if (!down_grant[i]) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + COUNT_WIDTH'(1);
               end
            end
            ST_HOLDOFF: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + COUNT_WIDTH'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // State, counter and pulse registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= expire_evt;
         end
      end

      assign timeout_pulse[i] = pulse_q;

`ifdef TIMER_STATS_EN
      logic [15:0] exp_cnt_q;

      // Saturating count of expiries for this channel.
      always_ff @(posedge clk) begin
         if (rst) begin
            exp_cnt_q <= '0;
         end else if (expire_evt && (exp_cnt_q != 16'hFFFF)) begin
            exp_cnt_q <= exp_cnt_q + 16'd1;
         end
      end

      assign expire_count[16*i +: 16] = exp_cnt_q;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_multi
// Purpose  : Self-checking bench for timer_multi (CHANNELS=4, COUNT_WIDTH=16,
//            HOLDOFF=2). Table-driven per-cycle vectors with a scoreboard
//            queue; a long saturation run; optional TIMER_STATS_EN checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_multi;

   logic        clk;
   logic        rst;
   logic [15:0] limit;
   logic [3:0]  up_req;
   logic [3:0]  up_grant;
   logic [3:0]  up_ack;
   logic [3:0]  down_req;
   logic [3:0]  down_grant;
   logic [3:0]  down_ack;
   logic [3:0]  timeout_pulse;
`ifdef TIMER_STATS_EN
   logic [63:0] expire_count;
`endif

   timer_multi #(
      .CHANNELS    (4),
      .COUNT_WIDTH (16),
      .HOLDOFF     (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .limit         (limit),
      .up_req        (up_req),
      .up_grant      (up_grant),
      .up_ack        (up_ack),
      .down_req      (down_req),
      .down_grant    (down_grant),
      .down_ack      (down_ack),
`ifdef TIMER_STATS_EN
      .expire_count  (expire_count),
`endif
      .timeout_pulse (timeout_pulse)
   );

   // One cycle of stimulus plus the outputs it must produce.
   typedef struct {
      logic        rst;
      logic [15:0] limit;
      logic [3:0]  req;
      logic [3:0]  grant;
      logic [3:0]  ack;
      logic [3:0]  exp_dr;
      logic [3:0]  exp_p;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   int pass_cnt = 0;
   int total    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic add(input logic r, input logic [15:0] lim, input logic [3:0] req,
                      input logic [3:0] g, input logic [3:0] edr, input logic [3:0] ep);
      vec_t v;
      v.rst = r; v.limit = lim; v.req = req; v.grant = g;
      v.ack = g ^ 4'b0110;
      v.exp_dr = edr; v.exp_p = ep;
      vecs.push_back(v);
   endtask

   // Drive one cycle: inputs after the falling edge, expectations into the
   // scoreboard, then pop and compare once combinational outputs settle.
   task automatic run_vec(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst        = v.rst;
      limit      = v.limit;
      up_req     = v.req;
      down_grant = v.grant;
      up_ack     = v.ack;
      sb.push_back(v);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("down_req", {60'd0, down_req}, {60'd0, e.exp_dr});
         check("timeout_pulse", {60'd0, timeout_pulse}, {60'd0, e.exp_p});
         check("up_grant", {60'd0, up_grant}, {60'd0, e.grant});
         check("down_ack", {60'd0, down_ack}, {60'd0, e.ack});
      end
   endtask

   task automatic run_table();
      for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);
      vecs.delete();
   endtask

   task automatic rep(input int n, input logic r, input logic [15:0] lim, input logic [3:0] req,
                      input logic [3:0] g, input logic [3:0] edr, input logic [3:0] ep);
      for (int k = 0; k < n; k++) add(r, lim, req, g, edr, ep);
   endtask

   initial begin
      rst = 1'b1; limit = '0; up_req = '0; down_grant = '0; up_ack = '0;

      // Reset: requests pass through, no pulses.
      rep(2, 1, 16'd0, 4'hF, 4'h0, 4'hF, 4'h0);
      add(1, 16'd0, 4'h5, 4'h0, 4'h5, 4'h0);

      // Basic expiry on channel 0: limit 3, masked cycles 3..5, pulse cycle 4.
      rep(3, 0, 16'd3, 4'hF, 4'h1, 4'hF, 4'h0);
      add(0, 16'd3, 4'hF, 4'h1, 4'hE, 4'h0);
      add(0, 16'd3, 4'hF, 4'h1, 4'hE, 4'h1);
      add(0, 16'd3, 4'hF, 4'h1, 4'hE, 4'h0);
      add(0, 16'd3, 4'hF, 4'h0, 4'hF, 4'h0);
      add(0, 16'd3, 4'h0, 4'h0, 4'h0, 4'h0);

      // Voluntary release on channel 1, then a fresh grant that expires on
      // a timeline starting from the new grant (channel was back in IDLE).
      rep(3, 0, 16'd5, 4'hF, 4'h2, 4'hF, 4'h0);
      rep(2, 0, 16'd5, 4'hF, 4'h0, 4'hF, 4'h0);
      rep(5, 0, 16'd5, 4'hF, 4'h2, 4'hF, 4'h0);
      add(0, 16'd5, 4'hF, 4'h2, 4'hD, 4'h0);
      add(0, 16'd5, 4'hF, 4'h2, 4'hD, 4'h2);
      add(0, 16'd5, 4'hF, 4'h2, 4'hD, 4'h0);
      add(0, 16'd5, 4'hF, 4'h0, 4'hF, 4'h0);

      // Limit lowered mid-grant on channel 2: expired in cycle 4, pulse 5.
      rep(4, 0, 16'd10, 4'hF, 4'h4, 4'hF, 4'h0);
      add(0, 16'd2, 4'hF, 4'h4, 4'hB, 4'h0);
      add(0, 16'd2, 4'hF, 4'h4, 4'hB, 4'h4);
      add(0, 16'd2, 4'hF, 4'h4, 4'hB, 4'h0);
      add(0, 16'd2, 4'hF, 4'h0, 4'hF, 4'h0);

      // Limit dropped to 0 just as channel 3 would expire: expiry cancelled.
      rep(3, 0, 16'd3, 4'hF, 4'h8, 4'hF, 4'h0);
      rep(3, 0, 16'd0, 4'hF, 4'h8, 4'hF, 4'h0);
      add(0, 16'd0, 4'hF, 4'h0, 4'hF, 4'h0);

      // Channels 0 and 2 together, limit 4: both pulse in cycle 5.
      rep(4, 0, 16'd4, 4'hF, 4'h5, 4'hF, 4'h0);
      add(0, 16'd4, 4'hF, 4'h5, 4'hA, 4'h0);
      add(0, 16'd4, 4'hF, 4'h5, 4'hA, 4'h5);
      add(0, 16'd4, 4'hF, 4'h5, 4'hA, 4'h0);
      add(0, 16'd4, 4'hF, 4'h0, 4'hF, 4'h0);

      // Same with rst in cycle 2: IDLE from cycle 3, so the still-held grant
      // restarts counting and only expires in cycle 7.
      rep(2, 0, 16'd4, 4'hF, 4'h5, 4'hF, 4'h0);
      add(1, 16'd4, 4'hF, 4'h5, 4'hF, 4'h0);
      rep(4, 0, 16'd4, 4'hF, 4'h5, 4'hF, 4'h0);
      add(0, 16'd4, 4'hF, 4'h5, 4'hA, 4'h0);
      add(0, 16'd4, 4'hF, 4'h5, 4'hA, 4'h5);
      add(0, 16'd4, 4'hF, 4'h5, 4'hA, 4'h0);
      add(0, 16'd4, 4'hF, 4'h0, 4'hF, 4'h0);

      // Reset coinciding with an expiry: pass-through, and the pulse is lost.
      rep(2, 0, 16'd2, 4'hF, 4'h1, 4'hF, 4'h0);
      add(1, 16'd2, 4'hF, 4'h1, 4'hF, 4'h0);
      rep(2, 0, 16'd2, 4'hF, 4'h0, 4'hF, 4'h0);

      run_table();

      // Timeout disabled for 70000 cycles; then limit=FFFF expires at once
      // only if the counter saturated instead of wrapping.
      begin
         vec_t v;
         v.rst = 0; v.limit = 16'd0; v.req = 4'hF; v.grant = 4'h1;
         v.ack = 4'h1; v.exp_dr = 4'hF; v.exp_p = 4'h0;
         for (int k = 0; k < 70000; k++) run_vec(v);
      end
      add(0, 16'hFFFF, 4'hF, 4'h1, 4'hE, 4'h0);
      add(0, 16'hFFFF, 4'hF, 4'h1, 4'hE, 4'h1);
      add(0, 16'hFFFF, 4'hF, 4'h1, 4'hE, 4'h0);
      add(0, 16'hFFFF, 4'hF, 4'h0, 4'hF, 4'h0);
      run_table();

`ifdef TIMER_STATS_EN
      // Three expiries on channel 3 after a clean reset.
      add(1, 16'd1, 4'hF, 4'h0, 4'hF, 4'h0);
      for (int r = 0; r < 3; r++) begin
         add(0, 16'd1, 4'hF, 4'h8, 4'hF, 4'h0);
         add(0, 16'd1, 4'hF, 4'h8, 4'h7, 4'h0);
         add(0, 16'd1, 4'hF, 4'h8, 4'h7, 4'h8);
         add(0, 16'd1, 4'hF, 4'h0, 4'h7, 4'h0);
         add(0, 16'd1, 4'hF, 4'h0, 4'hF, 4'h0);
      end
      run_table();
      check("expire_count_after3", expire_count, {16'd3, 16'd0, 16'd0, 16'd0});
      add(1, 16'd1, 4'hF, 4'h0, 4'hF, 4'h0);
      add(0, 16'd1, 4'hF, 4'h0, 4'hF, 4'h0);
      run_table();
      check("expire_count_cleared", expire_count, 64'd0);
`endif

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
